// File: rtl/pc_pkg.sv
// pc_pkg: shared PC constants and the next-PC select encoding
package pc_pkg;
  localparam logic [31:0] RESET_VEC = 32'h18C0;
  localparam logic [31:0] EXC_VEC = 32'h0080;
  localparam int PC_INC = 4;
  typedef enum logic [2:0] {EXC, HOLD, RET, CALL, JMP, BR, SEQ} pc_sel_e;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] sp;
  logic full, empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign top = mem[sp - AW'(1)];
  // entry storage needs no reset; a zero count makes stale entries invisible
  always_ff @(posedge clock) begin
    if (push) mem[sp] <= data;
  end
  // pointer, occupancy and one-cycle flag pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= push && full;
      underflow <= pop && empty;
      if (push) begin
        sp <= sp + AW'(1);
        count <= full ? count : count + CW'(1);
      end else if (pop && !empty) begin
        sp <= sp - AW'(1);
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with prioritized redirects and a return-address stack
module pc_ras import pc_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VEC),
  parameter int RAS_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        exception,
  input  logic                        jmp,
  input  logic                        call,
  input  logic                        ret,
  input  logic [ADDR_W-1:0]           jmp_target,
  input  logic                        branch,
  input  logic                        zero,
  input  logic [ADDR_W-1:0]           branch_offset,
  output logic [ADDR_W-1:0]           address,
  output logic                        redirect,
  output logic                        ras_overflow,
  output logic                        ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);
  pc_sel_e sel;
  logic [ADDR_W-1:0] seq_pc, top, next_pc;
  logic ret_hit, next_redirect;
  // priority decode and next-PC selection
  always_comb begin
    sel = exception ? EXC : stall ? HOLD : ret ? RET : call ? CALL : jmp ? JMP : (branch && !zero) ? BR : SEQ;
    seq_pc = address + ADDR_W'(PC_INC);
    ret_hit = ras_count != '0;
    next_pc = sel == EXC ? EXC_VECTOR :
              sel == HOLD ? address :
              sel == RET ? (ret_hit ? top : seq_pc) :
              (sel == CALL || sel == JMP) ? RESET_VECTOR + jmp_target :
              sel == BR ? address + branch_offset - ADDR_W'(PC_INC) : seq_pc;
    next_redirect = sel == EXC || sel == CALL || sel == JMP || sel == BR || (sel == RET && ret_hit);
  end
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clock(clock),
    .reset(reset),
    .push(sel == CALL),
    .pop(sel == RET),
    .data(seq_pc),
    .top(top),
    .count(ras_count),
    .overflow(ras_overflow),
    .underflow(ras_underflow)
  );
  // PC register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address <= RESET_VECTOR;
      redirect <= 1'b0;
    end else begin
      address <= next_pc;
      redirect <= next_redirect;
    end
  end
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed and random checks of pc_ras against a queue-based reference model
module tb_pc_ras;
  localparam logic [31:0] RV = 32'h18C0;
  localparam logic [31:0] EV = 32'h0080;
  localparam int DEPTH = 8;
  logic clock, reset, stall, exception, jmp, call, ret, branch, zero;
  logic [31:0] jmp_target, branch_offset, address;
  logic redirect, ras_overflow, ras_underflow;
  logic [3:0] ras_count;
  int errors = 0, checks = 0;
  logic [31:0] m_addr;
  logic [31:0] q [$];
  logic m_red, m_ovf, m_unf;

  pc_ras dut (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .jmp(jmp), .call(call), .ret(ret), .jmp_target(jmp_target),
    .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .address(address), .redirect(redirect), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .ras_count(ras_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".address"}, address, m_addr);
    chk({tag, ".redirect"}, 32'(redirect), 32'(m_red));
    chk({tag, ".overflow"}, 32'(ras_overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(ras_underflow), 32'(m_unf));
    chk({tag, ".count"}, 32'(ras_count), 32'(q.size()));
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = RV;
    m_red = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input string tag, input logic st, input logic ex, input logic j,
                      input logic c, input logic r, input logic br, input logic z,
                      input logic [31:0] tgt, input logic [31:0] off);
    stall = st; exception = ex; jmp = j; call = c; ret = r;
    branch = br; zero = z; jmp_target = tgt; branch_offset = off;
    m_red = 0; m_ovf = 0; m_unf = 0;
    if (ex) begin m_addr = EV; m_red = 1; end
    else if (st) begin end
    else if (r) begin
      if (q.size() > 0) begin m_addr = q.pop_back(); m_red = 1; end
      else begin m_addr = m_addr + 4; m_unf = 1; end
    end else if (c) begin
      if (q.size() == DEPTH) begin void'(q.pop_front()); m_ovf = 1; end
      q.push_back(m_addr + 4);
      m_addr = RV + tgt; m_red = 1;
    end else if (j) begin m_addr = RV + tgt; m_red = 1; end
    else if (br && !z) begin m_addr = m_addr + off - 4; m_red = 1; end
    else m_addr = m_addr + 4;
    @(posedge clock); #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #2;
    chk_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    stall = 0; exception = 0; jmp = 0; call = 0; ret = 0;
    branch = 0; zero = 0; jmp_target = 0; branch_offset = 0;
    reset = 1'b0;
    @(posedge clock); #1;
    apply_reset();
    chk("reset_addr_const", address, 32'h18C0);
    for (int i = 0; i < 3; i++) idle("idle");
    chk("idle3_addr_const", address, 32'h18CC);
    @(posedge clock); #1;
    apply_reset();
    idle("idle_to_18c4");
    step("call_100", 0, 0, 0, 1, 0, 0, 0, 32'h100, 0);
    chk("call_addr_const", address, 32'h19C0);
    step("ret", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("ret_addr_const", address, 32'h18C8);
    step("call_ret_both", 0, 0, 0, 1, 1, 0, 0, 32'h40, 0);
    step("jmp_1900", 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
    step("br_taken", 0, 0, 0, 0, 0, 1, 0, 0, -32'sd8);
    chk("br_addr_const", address, 32'h18F4);
    step("jmp_1900b", 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
    step("br_not_taken", 0, 0, 0, 0, 0, 1, 1, 0, -32'sd8);
    chk("brnt_addr_const", address, 32'h1904);
    for (int i = 0; i < 9; i++) step("nest_call", 0, 0, 0, 1, 0, 0, 0, 32'(i * 32'h40), 0);
    for (int i = 0; i < 9; i++) step("nest_ret", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("stall_jmp1", 1, 0, 1, 0, 0, 0, 0, 32'h200, 0);
    step("stall_jmp2", 1, 0, 1, 0, 0, 0, 0, 32'h200, 0);
    step("exception", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("exception", 1, 1, 1, 1, 1, 1, 0, 32'h200, 0);
    chk("exc_addr_const", address, 32'h0080);
    step("call_pre_stall", 0, 0, 0, 1, 0, 0, 0, 32'h10, 0);
    step("stall_hold", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_reset();
    step("after_reset_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("after_reset_seq");
    step("wrap_jmp", 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_E73C, 0);
    idle("wrap_seq");
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 40,
           $urandom_range(0, 1) == 1, $urandom() & 32'h0000_FFFC,
           32'($signed($urandom_range(0, 512)) - 256));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h18C0, meaning the reset address and the base for absolute jumps.
REQ-003 The block SHALL have parameter EXC_VECTOR, default 32'h0080, meaning the exception entry address.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 8, power of two >= 2, meaning the number of return-address-stack entries.
REQ-005 Port clock: input, 1 bit, rising-edge clock.
REQ-006 Port reset: input, 1 bit, asynchronous, active-high.
REQ-007 Port stall: input, 1 bit, holds the PC and the stack.
REQ-008 Port exception: input, 1 bit, redirects to EXC_VECTOR.
REQ-009 Port jmp: input, 1 bit, absolute jump request.
REQ-010 Port call: input, 1 bit, absolute jump that also pushes a return address.
REQ-011 Port ret: input, 1 bit, jump to the popped return address.
REQ-012 Port jmp_target: input, ADDR_W bits, jump/call offset from RESET_VECTOR.
REQ-013 Port branch, zero: inputs, 1 bit each; the branch is taken when branch && !zero.
REQ-014 Port branch_offset: input, ADDR_W bits, signed branch displacement.
REQ-015 Port address: output, ADDR_W bits, registered current PC.
REQ-016 Port redirect: output, 1 bit, registered; high for the cycle after any non-sequential PC update.
REQ-017 Port ras_overflow, ras_underflow: outputs, 1 bit each, registered one-cycle pulses.
REQ-018 Port ras_count: output, $clog2(RAS_DEPTH)+1 bits, number of valid stack entries.

Function
REQ-019 At each rising clock edge, the block SHALL apply exactly one action, in fixed priority order: exception > stall > ret > call > jmp > taken branch > sequential.
REQ-020 On exception, address SHALL load EXC_VECTOR, redirect SHALL be 1, and the stack SHALL be left unchanged.
REQ-021 On stall, address, the stack and ras_count SHALL hold; redirect, ras_overflow and ras_underflow SHALL be 0.
REQ-022 On ret with ras_count>0, address SHALL load the top entry, ras_count SHALL decrement, and redirect SHALL be 1.
REQ-023 On ret with ras_count==0, address SHALL be address+4, ras_underflow SHALL be 1 for one cycle, and redirect SHALL be 0.
REQ-024 On call, the block SHALL push address+4, load address with RESET_VECTOR+jmp_target, and set redirect to 1.
REQ-025 On call with ras_count==RAS_DEPTH, the push SHALL overwrite the oldest entry (circular), ras_count SHALL stay at RAS_DEPTH, and ras_overflow SHALL be 1 for one cycle.
REQ-026 On jmp, address SHALL load RESET_VECTOR+jmp_target, redirect SHALL be 1, and the stack SHALL be unchanged.
REQ-027 On a taken branch, address SHALL load address+$signed(branch_offset)-4, and redirect SHALL be 1.
REQ-028 Otherwise, address SHALL load address+4 and redirect SHALL be 0.
REQ-029 All address arithmetic SHALL be modulo 2^ADDR_W; wrap-around SHALL be silent.
REQ-030 When call and ret are both asserted, ret SHALL win and call SHALL be ignored; no push or pop beyond the ret occurs.
REQ-031 Flags not named by an action SHALL be 0 in that cycle.

Reset
REQ-032 While reset is high, the block SHALL set address=RESET_VECTOR, redirect=0, ras_overflow=0, ras_underflow=0, ras_count=0 and the stack pointer=0, regardless of clock.
REQ-033 Reset asserted mid-operation (including during stall) SHALL discard all stack contents; stack entry RAM need not be cleared.
REQ-034 The first rising edge after reset deassertion SHALL perform a normal priority evaluation.

Structure
REQ-035 A shared package pc_pkg SHALL hold the default RESET_VECTOR and EXC_VECTOR, the increment constant 4, and an enumerated type for the next-PC select (EXC, HOLD, RET, CALL, JMP, BR, SEQ).
REQ-036 The return-address stack SHALL be a sub-module ras_stack (parameters DEPTH and W; push, pop, top, count, overflow, underflow).
REQ-037 The pc_ras top level SHALL hold only the priority decode and the PC register.

Verification
REQ-038 Reset release, 3 idle cycles -> address 18C0, 18C4, 18C8, 18CC; redirect 0 throughout.
REQ-039 At 18C4, call with jmp_target=0x100 -> address 19C0 and ras_count 1; then ret -> address 18C8, ras_count 0, redirect 1.
REQ-040 At 1900, branch=1, zero=0, branch_offset=-8 -> address 18F4 and redirect 1; repeat with zero=1 -> address 1904.
REQ-041 RAS_DEPTH=8: 9 nested calls -> ras_overflow pulses on the 9th; 9 rets -> the first 8 return in LIFO order, the 9th raises ras_underflow and advances by 4.
REQ-042 Simultaneous stall+jmp for 2 cycles then exception -> address held, then 0080; reset pulsed during stall -> 18C0 and ras_count 0.
